// File: rtl/iob_cpu_bus_arbiter.sv
// Round-robin arbiter sharing one IOb native slave port between N requesters.
// One outstanding transaction, registered slave request, watchdog-terminated hung accesses.
module iob_cpu_bus_arbiter #(
    parameter int unsigned N_MASTERS = 2,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned TIMEOUT_W = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_MASTERS-1:0]            m_valid,
    input  logic [N_MASTERS*ADDR_W-1:0]     m_addr,
    input  logic [N_MASTERS*DATA_W-1:0]     m_wdata,
    input  logic [N_MASTERS*DATA_W/8-1:0]   m_wstrb,
    output logic [DATA_W-1:0]               m_rdata,
    output logic [N_MASTERS-1:0]            m_ready,
    output logic                            s_valid,
    output logic [ADDR_W-1:0]               s_addr,
    output logic [DATA_W-1:0]               s_wdata,
    output logic [DATA_W/8-1:0]             s_wstrb,
    input  logic [DATA_W-1:0]               s_rdata,
    input  logic                            s_ready,
    output logic [N_MASTERS-1:0]            grant,
    output logic                            busy,
    output logic                            timeout_err
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned PTR_W  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [PTR_W-1:0]       gidx_q, gidx_d;
    logic [TIMEOUT_W-1:0]   wd_q, wd_d;
    logic                   s_valid_q, s_valid_d;
    logic [ADDR_W-1:0]      s_addr_q, s_addr_d;
    logic [DATA_W-1:0]      s_wdata_q, s_wdata_d;
    logic [STRB_W-1:0]      s_wstrb_q, s_wstrb_d;
    logic [N_MASTERS-1:0]   grant_q, grant_d;

    logic                   found;
    logic [PTR_W-1:0]       sel;
    logic [PTR_W-1:0]       ptr_next;
    int unsigned            idx;

    // State and registered slave request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            gidx_q    <= '0;
            wd_q      <= '0;
            s_valid_q <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            s_wstrb_q <= '0;
            grant_q   <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gidx_q    <= gidx_d;
            wd_q      <= wd_d;
            s_valid_q <= s_valid_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
            s_wstrb_q <= s_wstrb_d;
            grant_q   <= grant_d;
        end
    end

    // Next state, round-robin pick and completion responses
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gidx_d      = gidx_q;
        wd_d        = wd_q;
        s_valid_d   = s_valid_q;
        s_addr_d    = s_addr_q;
        s_wdata_d   = s_wdata_q;
        s_wstrb_d   = s_wstrb_q;
        grant_d     = grant_q;
        m_ready     = '0;
        m_rdata     = '0;
        timeout_err = 1'b0;
        found       = 1'b0;
        sel         = '0;
        idx         = 0;

        // First requester at or after the pointer, wrapping
        for (int k = 0; k < int'(N_MASTERS); k++) begin
            idx = (32'(ptr_q) + 32'(k)) % N_MASTERS;
            if (!found && m_valid[PTR_W'(idx)]) begin
                found = 1'b1;
                sel   = PTR_W'(idx);
            end
        end

        ptr_next = (32'(gidx_q) == N_MASTERS - 1) ? '0 : gidx_q + PTR_W'(1);

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d      = BUSY;
                    s_valid_d    = 1'b1;
                    s_addr_d     = m_addr[32'(sel)*ADDR_W +: ADDR_W];
                    s_wdata_d    = m_wdata[32'(sel)*DATA_W +: DATA_W];
                    s_wstrb_d    = m_wstrb[32'(sel)*STRB_W +: STRB_W];
                    grant_d      = '0;
                    grant_d[sel] = 1'b1;
                    gidx_d       = sel;
                    wd_d         = '0;
                end
            end
            BUSY: begin
                wd_d = wd_q + TIMEOUT_W'(1);
                // s_ready wins over a coincident watchdog expiry
                if (s_ready || (&wd_q)) begin
                    m_ready   = grant_q;
                    state_d   = IDLE;
                    s_valid_d = 1'b0;
                    grant_d   = '0;
                    ptr_d     = ptr_next;
                    wd_d      = '0;
                    if (s_ready) begin
                        m_rdata = s_rdata;
                    end else begin
                        timeout_err = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign s_valid = s_valid_q;
    assign s_addr  = s_addr_q;
    assign s_wdata = s_wdata_q;
    assign s_wstrb = s_wstrb_q;
    assign grant   = grant_q;
    assign busy    = (state_q == BUSY);

endmodule

// File: tb/tb_iob_cpu_bus_arbiter.sv
// Directed bench for iob_cpu_bus_arbiter: 2 masters, 3-bit watchdog (timeout after 7 busy cycles).
module tb_iob_cpu_bus_arbiter;

    localparam int unsigned N  = 2;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TW = 3;

    logic              clk;
    logic              rst;
    logic [N-1:0]      m_valid;
    logic [N*AW-1:0]   m_addr;
    logic [N*DW-1:0]   m_wdata;
    logic [N*DW/8-1:0] m_wstrb;
    logic [DW-1:0]     m_rdata;
    logic [N-1:0]      m_ready;
    logic              s_valid;
    logic [AW-1:0]     s_addr;
    logic [DW-1:0]     s_wdata;
    logic [DW/8-1:0]   s_wstrb;
    logic [DW-1:0]     s_rdata;
    logic              s_ready;
    logic [N-1:0]      grant;
    logic              busy;
    logic              timeout_err;

    int total = 0;
    int bad   = 0;

    iob_cpu_bus_arbiter #(
        .N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_W(TW)
    ) dut (
        .clk(clk), .rst(rst),
        .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_rdata(m_rdata), .m_ready(m_ready),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_rdata(s_rdata), .s_ready(s_ready),
        .grant(grant), .busy(busy), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Compare the handshake/control outputs in one go
    task automatic ctl(input string tag, input logic sv, input logic [1:0] g,
                       input logic [1:0] mr, input logic te);
        check({tag, ".s_valid"}, 32'(s_valid), 32'(sv));
        check({tag, ".grant"}, 32'(grant), 32'(g));
        check({tag, ".m_ready"}, 32'(m_ready), 32'(mr));
        check({tag, ".timeout_err"}, 32'(timeout_err), 32'(te));
    endtask

    // Advance to just after the next rising edge; inputs change here
    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst     = 1'b1;
        m_valid = '0;
        m_addr  = '0;
        m_wdata = '0;
        m_wstrb = '0;
        s_rdata = '0;
        s_ready = 1'b0;
        tick;
        #1;
        ctl("reset", 1'b0, 2'b00, 2'b00, 1'b0);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.m_rdata", m_rdata, 32'h0);
        rst = 1'b0;

        // Single read from master 0, slave answers in cycle 3
        tick;
        m_valid = 2'b01;
        m_addr[0*AW +: AW] = 32'h100;
        #1;
        ctl("rd.c0", 1'b0, 2'b00, 2'b00, 1'b0);
        for (int c = 1; c <= 2; c++) begin
            tick;
            #1;
            ctl("rd.wait", 1'b1, 2'b01, 2'b00, 1'b0);
            check("rd.s_addr", s_addr, 32'h100);
        end
        tick;
        s_ready = 1'b1;
        s_rdata = 32'hDEADBEEF;
        #1;
        ctl("rd.c3", 1'b1, 2'b01, 2'b01, 1'b0);
        check("rd.m_rdata", m_rdata, 32'hDEADBEEF);
        tick;
        s_ready = 1'b0;
        m_valid = 2'b00;
        #1;
        ctl("rd.c4", 1'b0, 2'b00, 2'b00, 1'b0);
        check("rd.busy", 32'(busy), 32'd0);

        // Return the pointer to 0 before contention
        rst = 1'b1;
        tick;
        rst = 1'b0;

        // Contention with a zero-wait slave: grants alternate 01,10,01,10
        m_valid = 2'b11;
        m_addr[1*AW +: AW] = 32'h200;
        s_ready = 1'b1;
        s_rdata = 32'h0BADF00D;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] g;
            g = (i % 2 == 0) ? 2'b01 : 2'b10;
            tick;
            #1;
            ctl("rr.busy", 1'b1, g, g, 1'b0);
            check("rr.s_addr", s_addr, (i % 2 == 0) ? 32'h100 : 32'h200);
            tick;
            if (i == 3) m_valid = 2'b00;
            #1;
            ctl("rr.idle", 1'b0, 2'b00, 2'b00, 1'b0);
        end
        s_ready = 1'b0;

        // Write from master 1; a late master 0 request must not disturb it
        tick;
        m_valid = 2'b10;
        m_addr[1*AW +: AW]  = 32'h2000;
        m_wdata[1*DW +: DW] = 32'h12345678;
        m_wstrb[4 +: 4]     = 4'h3;
        for (int c = 1; c <= 3; c++) begin
            tick;
            if (c == 2) m_valid = 2'b11;
            #1;
            ctl("wr.hold", 1'b1, 2'b10, 2'b00, 1'b0);
            check("wr.s_addr", s_addr, 32'h2000);
            check("wr.s_wdata", s_wdata, 32'h12345678);
            check("wr.s_wstrb", 32'(s_wstrb), 32'h3);
        end
        tick;
        s_ready = 1'b1;
        #1;
        ctl("wr.done", 1'b1, 2'b10, 2'b10, 1'b0);
        tick;
        s_ready = 1'b0;
        m_valid = 2'b00;
        #1;
        ctl("wr.idle", 1'b0, 2'b00, 2'b00, 1'b0);

        // Watchdog: slave never answers, expiry 7 cycles after s_valid rises
        tick;
        m_valid = 2'b01;
        m_addr[0*AW +: AW] = 32'h300;
        s_rdata = 32'hCAFEF00D;
        for (int c = 1; c <= 7; c++) begin
            tick;
            #1;
            ctl("to.wait", 1'b1, 2'b01, 2'b00, 1'b0);
        end
        tick;
        #1;
        ctl("to.fire", 1'b1, 2'b01, 2'b01, 1'b1);
        check("to.m_rdata", m_rdata, 32'h0);
        tick;
        m_valid = 2'b00;
        s_ready = 1'b1;
        #1;
        ctl("to.stray", 1'b0, 2'b00, 2'b00, 1'b0);
        check("to.busy", 32'(busy), 32'd0);

        // s_ready coincident with expiry completes normally
        tick;
        s_ready = 1'b0;
        m_valid = 2'b01;
        for (int c = 1; c <= 7; c++) begin
            tick;
            #1;
            ctl("tie.wait", 1'b1, 2'b01, 2'b00, 1'b0);
        end
        tick;
        s_ready = 1'b1;
        s_rdata = 32'h55AA55AA;
        #1;
        ctl("tie.done", 1'b1, 2'b01, 2'b01, 1'b0);
        check("tie.m_rdata", m_rdata, 32'h55AA55AA);
        tick;
        s_ready = 1'b0;
        m_valid = 2'b00;
        #1;
        ctl("tie.idle", 1'b0, 2'b00, 2'b00, 1'b0);

        // Reset mid-transaction (pointer is 1 here); after reset index 0 leads again
        tick;
        m_valid = 2'b01;
        tick;
        #1;
        ctl("rst.busy", 1'b1, 2'b01, 2'b00, 1'b0);
        s_ready = 1'b1;
        rst = 1'b1;
        #1;
        ctl("rst.now", 1'b0, 2'b00, 2'b00, 1'b0);
        check("rst.busy_o", 32'(busy), 32'd0);
        tick;
        s_ready = 1'b0;
        rst = 1'b0;
        m_valid = 2'b11;
        tick;
        #1;
        ctl("rst.after", 1'b1, 2'b01, 2'b00, 1'b0);
        check("rst.s_addr", s_addr, 32'h300);
        s_ready = 1'b1;
        #1;
        check("rst.m_ready", 32'(m_ready), 32'h1);
        tick;
        m_valid = 2'b00;
        s_ready = 1'b0;
        #1;
        ctl("rst.idle", 1'b0, 2'b00, 2'b00, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
